// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the mARC control unit: one-hot state register,
// memory request/acknowledge stalls, halt/resume and a retired-instruction counter.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             opc1,
  input  logic [3:0]       opc2,
  input  logic             mem_ack,
  input  logic             halt_req,
  input  logic             run,
  output logic [13:0]      state,
  output logic             mem_req,
  output logic             ir_load,
  output logic             pc_update,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [13:0] S_IF     = 14'h0001;
  localparam logic [13:0] S_ID     = 14'h0002;
  localparam logic [13:0] S_OF_ALU = 14'h0004;
  localparam logic [13:0] S_EX_ALU = 14'h0008;
  localparam logic [13:0] S_OF_MEM = 14'h0010;
  localparam logic [13:0] S_EX_MEM = 14'h0020;
  localparam logic [13:0] S_OF_JMP = 14'h0040;
  localparam logic [13:0] S_EX_JMP = 14'h0080;
  localparam logic [13:0] S_OF_SET = 14'h0100;
  localparam logic [13:0] S_EX_SET = 14'h0200;
  localparam logic [13:0] S_LINK   = 14'h0400;
  localparam logic [13:0] S_CALL   = 14'h0800;
  localparam logic [13:0] S_UPC    = 14'h1000;
  localparam logic [13:0] S_HALT   = 14'h2000;

  logic [13:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Instruction class is decided only in ID; opcode fields are don't-care elsewhere.
  function automatic logic [13:0] decode_class(input logic f_call, input logic [3:0] f_op);
    logic [13:0] nxt;
    if (f_call)                    nxt = S_LINK;
    else if (f_op[3:1] == 3'b011)  nxt = S_OF_MEM;
    else if (f_op == 4'b1001)      nxt = S_OF_JMP;
    else if (f_op[3:1] == 3'b101)  nxt = S_OF_SET;
    else                           nxt = S_OF_ALU;
    return nxt;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:     if (mem_ack) state_d = S_ID;
      S_ID:     state_d = decode_class(opc1, opc2);
      S_OF_ALU: state_d = S_EX_ALU;
      S_OF_MEM: state_d = S_EX_MEM;
      S_OF_JMP: state_d = S_EX_JMP;
      S_OF_SET: state_d = S_EX_SET;
      S_LINK:   state_d = S_CALL;
      S_EX_MEM: if (mem_ack) state_d = S_UPC;
      S_EX_ALU,
      S_EX_JMP,
      S_EX_SET,
      S_CALL:   state_d = S_UPC;
      S_UPC:    state_d = halt_req ? S_HALT : S_IF;
      S_HALT:   if (run) state_d = S_IF;
      // Any non-one-hot value recovers to a fresh fetch.
      default:  state_d = S_IF;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_UPC) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign mem_req     = (state_q == S_IF) || (state_q == S_EX_MEM);
  assign ir_load     = (state_q == S_IF) && mem_ack;
  assign pc_update   = (state_q == S_UPC);
  assign halted      = (state_q == S_HALT);
  assign instr_count = cnt_q;

endmodule
